instr_register_arbiter: RTL and testbench

//  Round-robin write arbiter and FIFO sequencer in front of instr_register.

---
 rtl/instr_register_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/instr_register_arbiter.sv | 168 ++++++++++++++++
 tb/tb_instr_register_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its write arbiter / FIFO sequencer.
// Opcode, operand, address and instruction word layouts are fixed by instr_register.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    localparam int MAX_REQ = 8;

    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: request vector plus enable to a one-hot grant.
// Priority pointer moves to the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    last_q;
    logic [IW-1:0]    sel;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;

    // Pick the first requester above the last winner, else the lowest one.
    always_comb begin
        grant  = '0;
        mask   = '0;
        sel    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            mask[j] = (j > int'(last_q));
        end
        masked = req & mask;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                sel = IW'(j);
            end
        end
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (masked[j]) begin
                sel = IW'(j);
            end
        end
        if (en && (|req)) begin
            grant[sel] = 1'b1;
        end
    end

    // Last-winner pointer; reset value makes requester 0 the first choice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= IW'(N_REQ - 1);
        end else if (en && (|req)) begin
            last_q <= sel;
        end
    end

endmodule

// File: rtl/instr_register_arbiter.sv
// Round-robin write arbiter and circular-queue sequencer for instr_register.
// One registered write stage, committed-entry count and a source-id side array.
import instr_register_pkg::*;

module instr_register_arbiter #(
    parameter int N_REQ = 2,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  opcode_t  [N_REQ-1:0]       req_opcode,
    input  operand_t [N_REQ-1:0]       req_op_a,
    input  operand_t [N_REQ-1:0]       req_op_b,
    input  logic                       flush,
    output logic                       load_en,
    output opcode_t                    opcode,
    output operand_t                   operand_a,
    output operand_t                   operand_b,
    output address_t                   write_pointer,
    output address_t                   read_pointer,
    input  instruction_t               instruction_word,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output instruction_t               rsp_word,
    output logic [$clog2(N_REQ)-1:0]   rsp_src,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0] grant;
    logic             arb_en;
    logic             xfer;
    logic             commit;
    logic             pop;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    occ;

    logic [IW-1:0]    gnt_idx;
    opcode_t          gnt_opc;
    operand_t         gnt_a;
    operand_t         gnt_b;

    logic             stg_valid;
    opcode_t          stg_opc;
    operand_t         stg_a;
    operand_t         stg_b;
    logic [IW-1:0]    stg_src;
    address_t         stg_ptr;

    address_t         wr_ptr;
    address_t         rd_ptr;

    logic [IW-1:0]    src_mem [DEPTH];

    // An entry in the write stage already owns a slot, so it counts as occupied.
    assign occ    = count_q + CW'(stg_valid);
    assign arb_en = !flush && (occ < CW'(DEPTH));

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .en      (arb_en),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign commit    = stg_valid && !flush;
    assign pop       = rsp_valid && rsp_ready && !flush;

    // Select the granted requester's payload.
    always_comb begin
        gnt_idx = '0;
        gnt_opc = ZERO;
        gnt_a   = '0;
        gnt_b   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant[j]) begin
                gnt_idx = IW'(j);
                gnt_opc = req_opcode[j];
                gnt_a   = req_op_a[j];
                gnt_b   = req_op_b[j];
            end
        end
    end

    // Write stage: drives the register's write port one cycle after the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= 1'b0;
            stg_opc   <= ZERO;
            stg_a     <= '0;
            stg_b     <= '0;
            stg_src   <= '0;
            stg_ptr   <= '0;
        end else begin
            stg_valid <= xfer;
            if (xfer) begin
                stg_opc <= gnt_opc;
                stg_a   <= gnt_a;
                stg_b   <= gnt_b;
                stg_src <= gnt_idx;
                stg_ptr <= wr_ptr;
            end
        end
    end

    // Queue pointers and committed count; flush drops everything committed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (xfer) begin
                wr_ptr <= wr_ptr + address_t'(1);
            end
            if (flush) begin
                count_q <= '0;
                rd_ptr  <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + address_t'(1);
                end
                unique case ({commit, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Source id of each committed entry, kept alongside the register stack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                src_mem[i] <= '0;
            end
        end else if (commit) begin
            src_mem[stg_ptr] <= stg_src;
        end
    end

    assign load_en       = stg_valid;
    assign opcode        = stg_opc;
    assign operand_a     = stg_a;
    assign operand_b     = stg_b;
    assign write_pointer = stg_ptr;
    assign read_pointer  = rd_ptr;

    assign rsp_valid = (count_q != '0);
    assign rsp_word  = instruction_word;
    assign rsp_src   = src_mem[rd_ptr];
    assign count     = count_q;
    assign full      = (occ == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_instr_register_arbiter.sv
// Bench for instr_register_arbiter with a behavioural instr_register model.
// Vector table for arbitration, scoreboard for response order and contents.
module tb_instr_register_arbiter;
    import instr_register_pkg::*;

    localparam int N_REQ = 2;
    localparam int DEPTH = 32;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    opcode_t  [N_REQ-1:0] req_opcode;
    operand_t [N_REQ-1:0] req_op_a;
    operand_t [N_REQ-1:0] req_op_b;
    logic                 flush = 1'b0;
    logic                 load_en;
    opcode_t              opcode;
    operand_t             operand_a;
    operand_t             operand_b;
    address_t             write_pointer;
    address_t             read_pointer;
    instruction_t         instruction_word;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    instruction_t         rsp_word;
    logic [0:0]           rsp_src;
    logic [5:0]           count;
    logic                 full;
    logic                 empty;

    always #5 clk = ~clk;

    instr_register_arbiter #(
        .N_REQ (N_REQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_opcode       (req_opcode),
        .req_op_a         (req_op_a),
        .req_op_b         (req_op_b),
        .flush            (flush),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_word         (rsp_word),
        .rsp_src          (rsp_src),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
        case (o)
            PASSA:   return result_t'(a);
            PASSB:   return result_t'(b);
            ADD:     return result_t'(a) + result_t'(b);
            SUB:     return result_t'(a) - result_t'(b);
            MULT:    return result_t'(a) * result_t'(b);
            default: return '0;
        endcase
    endfunction

    instruction_t mem [DEPTH];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load_en) begin
            mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                                    result: calc(opcode, operand_a, operand_b)};
        end
    end

    assign instruction_word = mem[read_pointer];

    typedef struct {
        opcode_t  opc;
        operand_t a;
        operand_t b;
        int       src;
    } exp_t;

    typedef struct {
        logic [1:0] v;
        logic [1:0] rdy;
        logic       ld;
        logic [4:0] wp;
        int         cnt;
    } vec_t;

    exp_t         sb[$];
    instruction_t got[$];
    vec_t         tv[6];
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp with a=%0d expected none", rsp_word.op_a);
        end else begin
            e = sb.pop_front();
            chk("rsp_opc", rsp_word.opc, e.opc);
            chk("rsp_op_a", rsp_word.op_a, e.a);
            chk("rsp_op_b", rsp_word.op_b, e.b);
            chk("rsp_src", rsp_src, e.src);
            got.push_back(rsp_word);
        end
    endtask

    // Called at posedge+1; drives one cycle and scores transfers/pops.
    task automatic cyc(input logic [1:0] v, input logic rr, input logic fl);
        req_valid = v;
        rsp_ready = rr;
        flush     = fl;
        #2;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i])
                sb.push_back('{opc: req_opcode[i], a: req_op_a[i], b: req_op_b[i], src: i});
        end
        if (fl) sb.delete();
        else if (rsp_valid && rsp_ready) pop_chk();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) cyc(2'b00, 1'b1, 1'b0);
        chk("drain_left", sb.size(), 0);
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_en", load_en, 0);
        chk("rst_opcode", opcode, ZERO);
        chk("rst_op_a", operand_a, 0);
        chk("rst_op_b", operand_b, 0);
        chk("rst_wp", write_pointer, 0);
        chk("rst_rp", read_pointer, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        sb.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        address_t wp0, wp1, rp0, wpf;

        req_opcode = '{ZERO, ZERO};
        req_op_a   = '{0, 0};
        req_op_b   = '{0, 0};

        tv[0] = '{v: 2'b11, rdy: 2'b01, ld: 1'b0, wp: 5'd0, cnt: 0};
        tv[1] = '{v: 2'b11, rdy: 2'b10, ld: 1'b1, wp: 5'd0, cnt: 0};
        tv[2] = '{v: 2'b11, rdy: 2'b01, ld: 1'b1, wp: 5'd1, cnt: 1};
        tv[3] = '{v: 2'b11, rdy: 2'b10, ld: 1'b1, wp: 5'd2, cnt: 2};
        tv[4] = '{v: 2'b00, rdy: 2'b00, ld: 1'b1, wp: 5'd3, cnt: 3};
        tv[5] = '{v: 2'b00, rdy: 2'b00, ld: 1'b0, wp: 5'd3, cnt: 4};

        do_reset();
        @(posedge clk);
        #1;

        // Arbitration table
        req_opcode[0] = PASSA; req_op_a[0] = 10; req_op_b[0] = 20;
        req_opcode[1] = PASSB; req_op_a[1] = 30; req_op_b[1] = 40;
        for (int i = 0; i < 6; i++) begin
            req_valid = tv[i].v;
            rsp_ready = 1'b0;
            #1;
            chk($sformatf("arb_ready_%0d", i), req_ready, tv[i].rdy);
            chk($sformatf("arb_load_%0d", i), load_en, tv[i].ld);
            chk($sformatf("arb_wp_%0d", i), write_pointer, tv[i].wp);
            chk($sformatf("arb_count_%0d", i), count, tv[i].cnt);
            cyc(tv[i].v, 1'b0, 1'b0);
        end
        drain();

        // Datapath results
        req_opcode[0] = ADD; req_op_a[0] = 5;  req_op_b[0] = 3;
        req_opcode[1] = SUB; req_op_a[1] = -4; req_op_b[1] = 6;
        got.delete();
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        drain();
        chk("dp_nrsp", got.size(), 2);
        if (got.size() >= 2) begin
            chk("dp_add_result", got[0].result, 8);
            chk("dp_sub_result", got[1].result, -10);
        end

        // Reset mid-operation, then fill to full and wrap
        req_opcode[0] = PASSA;
        cyc(2'b01, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 40 && sb.size() < DEPTH; k++) begin
            req_op_a[0] = k;
            req_op_b[0] = -k;
            cyc(2'b01, 1'b0, 1'b0);
        end
        req_op_a[0] = 1000;
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("full_writes", sb.size(), DEPTH);
        chk("full_flag", full, 1);
        chk("full_ready", req_ready, 0);
        chk("full_count", count, DEPTH);
        chk("full_no_load", load_en, 0);
        cyc(2'b01, 1'b1, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("wrap_ready", req_ready, 2'b01);
        cyc(2'b01, 1'b0, 1'b0);
        req_valid = 2'b00;
        #1;
        chk("wrap_load", load_en, 1);
        chk("wrap_wp", write_pointer, 0);
        cyc(2'b00, 1'b0, 1'b0);
        drain();

        // Commit and pop in the same cycle
        req_op_a[0] = 100;
        cyc(2'b01, 1'b0, 1'b0);
        req_valid = 2'b00;
        #1;
        wp0 = write_pointer;
        cyc(2'b00, 1'b0, 1'b0);
        chk("sim_count1", count, 1);
        req_op_a[0] = 101;
        cyc(2'b01, 1'b0, 1'b0);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        #1;
        rp0 = read_pointer;
        wp1 = write_pointer;
        chk("sim_load", load_en, 1);
        chk("sim_wp_adv", wp1, address_t'(wp0 + 5'd1));
        cyc(2'b00, 1'b1, 1'b0);
        chk("sim_count_hold", count, 1);
        chk("sim_rp_adv", read_pointer, address_t'(rp0 + 5'd1));
        drain();

        // Flush with a write in flight
        req_opcode[0] = PASSB;
        for (int k = 0; k < 6; k++) begin
            req_op_a[0] = 200 + k;
            cyc(2'b01, 1'b0, 1'b0);
        end
        req_valid = 2'b01;
        flush     = 1'b1;
        #1;
        chk("fl_count5", count, 5);
        chk("fl_inflight", load_en, 1);
        chk("fl_no_grant", req_ready, 0);
        wpf = write_pointer;
        cyc(2'b01, 1'b0, 1'b1);
        req_valid = 2'b00;
        flush     = 1'b0;
        #1;
        chk("fl_count0", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_rsp_valid", rsp_valid, 0);
        chk("fl_rp", read_pointer, address_t'(wpf + 5'd1));
        req_op_a[0] = 777;
        got.delete();
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        drain();
        chk("fl_nrsp", got.size(), 1);
        if (got.size() >= 1) chk("fl_first_read", got[0].op_a, 777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
